// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round sequencer and its datapath blocks.
// Holds the round count, the sequencer FSM encoding, the initial round constant
// and the GF(2^8) helpers (xtime, multiply, S-box) used by the round logic.
package aes_pkg;

  localparam int unsigned NR = 10;

  // Round constant word with the byte in [31:24] and zeros below.
  localparam logic [31:0] RCON_INIT = 32'h0100_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } aes_state_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as the affine map of the field inverse. The inverse is x^254,
  // built as the product x^2 * x^4 * ... * x^128 (0 maps to 0 as required).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and the current round constant word.
// Ports:
//   key_i   128-bit current round key
//   rcon_i  32-bit round constant word (constant byte in [31:24])
//   key_o   128-bit next round key
module key_expansion (
  input  logic [127:0] key_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] key_o
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // RotWord then SubWord, then the round constant.
  assign rot_w3 = {w3[23:0], w3[31:24]};
  assign temp   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                   sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ rcon_i;

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/normalRound.sv
// One full AES round (rounds 1..9): SubBytes, ShiftRows, MixColumns and
// AddRoundKey with the key expanded from the previous round key.
// Ports:
//   state_i  128-bit state entering the round
//   key_i    128-bit previous round key
//   rcon_i   32-bit round constant word for this round's key step
//   state_o  128-bit state leaving the round
//   key_o    128-bit round key used by this round
module normalRound (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] state_o,
  output logic [127:0] key_o
);
  import aes_pkg::*;

  logic [127:0] sub_state;
  logic [127:0] shift_state;
  logic [127:0] mix_state;
  logic [127:0] round_key;

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    // 3*a is written as xtime(a) ^ a.
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  subBytes u_sub_bytes (
    .data_i (state_i),
    .data_o (sub_state)
  );

  shiftRows u_shift_rows (
    .data_i (sub_state),
    .data_o (shift_state)
  );

  key_expansion u_key_expansion (
    .key_i  (key_i),
    .rcon_i (rcon_i),
    .key_o  (round_key)
  );

  always_comb begin
    mix_state = '0;
    for (int c = 0; c < 4; c++) begin
      mix_state[32*c +: 32] = mix_column(shift_state[32*c +: 32]);
    end
  end

  assign state_o = mix_state ^ round_key;
  assign key_o   = round_key;

endmodule

// File: rtl/shiftRows.sv
// AES ShiftRows: row r of the state is rotated left by r columns.
// State byte n (n = 4*column + row) sits at bits [127-8n -: 8].
// Ports:
//   data_i  128-bit state in
//   data_o  128-bit shifted state out
module shiftRows (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        data_o[8*(15-(4*c+r)) +: 8] = data_i[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
  end

endmodule

// File: rtl/subBytes.sv
// AES SubBytes: applies the S-box to each of the 16 bytes of the state.
// Ports:
//   data_i  128-bit state in
//   data_o  128-bit substituted state out
module subBytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  import aes_pkg::*;

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, 11 cycles from accepted
// start to the done pulse. Rounds 1..9 run through normalRound; round 10
// (no MixColumns) is built from key_expansion, subBytes and shiftRows.
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       encrypt request, accepted only while ready
//   plaintext   128-bit input block, sampled on the accepting edge
//   key         128-bit cipher key, sampled on the accepting edge
//   ready       idle and able to accept start
//   busy        block in flight (inverse of ready)
//   done        one-cycle pulse, ciphertext valid
//   ciphertext  128-bit result, held until the next done
module aes_round_sequencer #(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);
  import aes_pkg::*;

  // Only NR = 10 is supported; the round counter is sized for it.
  localparam logic [3:0] LastNormalRound = 4'(NR - 1);

  aes_state_e   st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  rcon_q, rcon_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] ciphertext_q, ciphertext_d;
  logic         done_q, done_d;

  logic [127:0] round_state;
  logic [127:0] round_key;
  logic [127:0] final_sub;
  logic [127:0] final_shift;
  logic [127:0] final_key;

  normalRound u_normal_round (
    .state_i (state_q),
    .key_i   (key_q),
    .rcon_i  (rcon_q),
    .state_o (round_state),
    .key_o   (round_key)
  );

  // Final round: same key step, no MixColumns.
  key_expansion u_final_key (
    .key_i  (key_q),
    .rcon_i (rcon_q),
    .key_o  (final_key)
  );

  subBytes u_final_sub (
    .data_i (state_q),
    .data_o (final_sub)
  );

  shiftRows u_final_shift (
    .data_i (final_sub),
    .data_o (final_shift)
  );

  always_comb begin
    st_d         = st_q;
    state_d      = state_q;
    key_d        = key_q;
    rcon_d       = rcon_q;
    round_cnt_d  = round_cnt_q;
    ciphertext_d = ciphertext_q;
    done_d       = 1'b0;
    case (st_q)
      StIdle: begin
        if (start) begin
          state_d     = plaintext ^ key;
          key_d       = key;
          rcon_d      = RCON_INIT;
          round_cnt_d = 4'd1;
          st_d        = StRound;
        end
      end
      StRound: begin
        state_d     = round_state;
        key_d       = round_key;
        rcon_d      = {xtime(rcon_q[31:24]), 24'h00_0000};
        round_cnt_d = round_cnt_q + 4'd1;
        if (round_cnt_q == LastNormalRound) st_d = StFinal;
      end
      StFinal: begin
        ciphertext_d = final_shift ^ final_key;
        done_d       = 1'b1;
        st_d         = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      state_q      <= '0;
      key_q        <= '0;
      rcon_q       <= RCON_INIT;
      round_cnt_q  <= 4'd0;
      ciphertext_q <= '0;
      done_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      state_q      <= state_d;
      key_q        <= key_d;
      rcon_q       <= rcon_d;
      round_cnt_q  <= round_cnt_d;
      ciphertext_q <= ciphertext_d;
      done_q       <= done_d;
    end
  end

  assign ready      = (st_q == StIdle);
  assign busy       = ~ready;
  assign done       = done_q;
  assign ciphertext = ciphertext_q;

endmodule
